round_sequencer: RTL and testbench

//  Central FSM for the memory game: replaces the ad-hoc delay/lrst/lpge counters in the top level.

---
 rtl/game_pkg.sv | 36 +++
 rtl/phase_timer.sv | 34 +++
 rtl/round_sequencer.sv | 161 ++++++++++++++++
 tb/tb_round_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants for the memory game: sequencer state codes, one-hot level codes and slot masks.
package game_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RRST  = 3'd1;
  localparam logic [2:0] ST_GEN   = 3'd2;
  localparam logic [2:0] ST_SHOW  = 3'd3;
  localparam logic [2:0] ST_INPUT = 3'd4;
  localparam logic [2:0] ST_JUDGE = 3'd5;
  localparam logic [2:0] ST_GAP   = 3'd6;
  localparam logic [2:0] ST_DONE  = 3'd7;

  localparam logic [2:0] LV_1 = 3'b001;
  localparam logic [2:0] LV_2 = 3'b010;
  localparam logic [2:0] LV_3 = 3'b100;

  localparam logic [15:0] MASK_8  = 16'h00FF;
  localparam logic [15:0] MASK_12 = 16'h0FFF;
  localparam logic [15:0] MASK_16 = 16'hFFFF;

  function automatic logic level_legal(logic [2:0] lv);
    return (lv == LV_1) || (lv == LV_2) || (lv == LV_3);
  endfunction

  function automatic logic [15:0] level_mask(logic [2:0] lv);
    logic [15:0] m;
    case (lv)
      LV_1:    m = MASK_8;
      LV_2:    m = MASK_12;
      LV_3:    m = MASK_16;
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter with zero flag; load wins over decrement, and it saturates at zero.
module phase_timer #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/round_sequencer.sv
// Round FSM for the memory game: local reset, generate, show, input, judge, gap; counts rounds,
// wins and the final score.
module round_sequencer #(
  parameter int unsigned NUM_ROUNDS    = 10,
  parameter int unsigned SUB_RST_CYC   = 2,
  parameter int unsigned GAP_CYC       = 3,
  parameter int unsigned INPUT_TIMEOUT = 30000,
  parameter int unsigned SCORE_PER_WIN = 10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        level_valid_i,
  input  logic [2:0]  level_i,
  input  logic        start_i,
  input  logic        gen_done_i,
  input  logic        show_done_i,
  input  logic        input_done_i,
  input  logic        round_win_i,
  output logic        sub_rst_o,
  output logic        gen_en_o,
  output logic [15:0] lv_mask_o,
  output logic [4:0]  round_count_o,
  output logic [3:0]  answer_count_o,
  output logic [6:0]  score_o,
  output logic        game_end_o,
  output logic        timeout_o
);
  import game_pkg::*;

  logic [2:0]  state_q, state_d;
  logic        start_q, start_edge_q;
  logic [15:0] lv_mask_q, lv_mask_d;
  logic [4:0]  round_count_q, round_count_d;
  logic [3:0]  answer_count_q, answer_count_d;
  logic [6:0]  score_q, score_d;
  logic        timeout_q, timeout_d;
  logic        tmr_load, tmr_dec, tmr_zero, next_round;
  logic [15:0] tmr_val;

  phase_timer #(
    .Width(16)
  ) u_phase_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d        = state_q;
    lv_mask_d      = lv_mask_q;
    round_count_d  = round_count_q;
    answer_count_d = answer_count_q;
    score_d        = score_q;
    timeout_d      = 1'b0;
    tmr_load       = 1'b0;
    tmr_dec        = 1'b0;
    tmr_val        = 16'(SUB_RST_CYC - 1);
    next_round     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge_q && level_valid_i && level_legal(level_i)) begin
          lv_mask_d      = level_mask(level_i);
          round_count_d  = '0;
          answer_count_d = '0;
          score_d        = '0;
          tmr_load       = 1'b1;
          state_d        = ST_RRST;
        end
      end
      ST_RRST: begin
        if (tmr_zero) state_d = ST_GEN;
        else          tmr_dec = 1'b1;
      end
      ST_GEN: begin
        if (gen_done_i) state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (show_done_i) begin
          tmr_load = 1'b1;
          tmr_val  = 16'(INPUT_TIMEOUT - 1);
          state_d  = ST_INPUT;
        end
      end
      ST_INPUT: begin
        tmr_dec = 1'b1;
        // A response arriving on the expiry cycle still counts as a normal answer.
        if (input_done_i) begin
          state_d = ST_JUDGE;
        end else if ((INPUT_TIMEOUT != 0) && tmr_zero) begin
          timeout_d = 1'b1;
          state_d   = ST_JUDGE;
        end
      end
      ST_JUDGE: begin
        round_count_d = round_count_q + 5'd1;
        if (round_win_i && !timeout_q) answer_count_d = answer_count_q + 4'd1;
        if (GAP_CYC != 0) begin
          tmr_load = 1'b1;
          tmr_val  = 16'(GAP_CYC - 1);
          state_d  = ST_GAP;
        end else begin
          next_round = 1'b1;
        end
      end
      ST_GAP: begin
        if (tmr_zero) next_round = 1'b1;
        else          tmr_dec    = 1'b1;
      end
      ST_DONE: begin
        if (start_edge_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (next_round) begin
      if (round_count_d == 5'(NUM_ROUNDS)) begin
        state_d = ST_DONE;
        score_d = 7'(32'(answer_count_d) * SCORE_PER_WIN);
      end else begin
        tmr_load = 1'b1;
        tmr_val  = 16'(SUB_RST_CYC - 1);
        state_d  = ST_RRST;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      start_q        <= 1'b0;
      start_edge_q   <= 1'b0;
      lv_mask_q      <= '0;
      round_count_q  <= '0;
      answer_count_q <= '0;
      score_q        <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_q        <= start_i;
      start_edge_q   <= start_i & ~start_q;
      lv_mask_q      <= lv_mask_d;
      round_count_q  <= round_count_d;
      answer_count_q <= answer_count_d;
      score_q        <= score_d;
      timeout_q      <= timeout_d;
    end
  end

  assign sub_rst_o      = !((state_q == ST_IDLE) || (state_q == ST_RRST) || (state_q == ST_DONE));
  assign gen_en_o       = (state_q == ST_GEN);
  assign game_end_o     = (state_q == ST_DONE);
  assign lv_mask_o      = lv_mask_q;
  assign round_count_o  = round_count_q;
  assign answer_count_o = answer_count_q;
  assign score_o        = score_q;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer: table of whole games plus hand-timed corner sequences.
module tb_round_sequencer;

  logic        clk = 1'b0;
  logic        rst_ni, level_valid_i, start_i, gen_done_i, show_done_i, input_done_i, round_win_i;
  logic [2:0]  level_i;
  logic        sub_rst_o, gen_en_o, game_end_o, timeout_o;
  logic [15:0] lv_mask_o;
  logic [4:0]  round_count_o;
  logic [3:0]  answer_count_o;
  logic [6:0]  score_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  round_sequencer #(
    .NUM_ROUNDS    (10),
    .SUB_RST_CYC   (2),
    .GAP_CYC       (3),
    .INPUT_TIMEOUT (50),
    .SCORE_PER_WIN (10)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .level_valid_i  (level_valid_i),
    .level_i        (level_i),
    .start_i        (start_i),
    .gen_done_i     (gen_done_i),
    .show_done_i    (show_done_i),
    .input_done_i   (input_done_i),
    .round_win_i    (round_win_i),
    .sub_rst_o      (sub_rst_o),
    .gen_en_o       (gen_en_o),
    .lv_mask_o      (lv_mask_o),
    .round_count_o  (round_count_o),
    .answer_count_o (answer_count_o),
    .score_o        (score_o),
    .game_end_o     (game_end_o),
    .timeout_o      (timeout_o)
  );

  typedef struct {
    logic [2:0]  level;
    logic [9:0]  wins;     // bit r = round r+1 answered correctly
    logic        special;  // round 1 times out, round 2 answers on the expiry cycle
    logic [15:0] mask;
    int          ans;
    int          score;
  } game_t;

  game_t games[5];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_gen();
    int n = 0;
    while (!gen_en_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("gen_wait", int'(gen_en_o), 1);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // d >= 0: input_done raised d cycles into INPUT; d < 0: no response, expect timeout.
  task automatic play_round(input int r, input logic win, input int d, input int exp_ans);
    wait_gen();
    round_win_i = win;
    gen_done_i  = 1'b1;
    @(negedge clk);
    gen_done_i  = 1'b0;
    chk("gen_en_drop", int'(gen_en_o), 0);
    @(negedge clk);
    show_done_i = 1'b1;
    @(negedge clk);
    show_done_i = 1'b0;
    if (d < 0) begin
      int early = 0;
      for (int k = 1; k <= 49; k++) begin
        @(negedge clk);
        if (timeout_o) early++;
      end
      chk("timeout_early", early, 0);
      @(negedge clk);
      chk("timeout_pulse", int'(timeout_o), 1);
    end else begin
      repeat (d) @(negedge clk);
      input_done_i = 1'b1;
      @(negedge clk);
      input_done_i = 1'b0;
      chk("timeout_none", int'(timeout_o), 0);
    end
    @(negedge clk);
    chk("timeout_clear", int'(timeout_o), 0);
    chk("round_count", int'(round_count_o), r + 1);
    chk("answer_count", int'(answer_count_o), exp_ans);
  endtask

  task automatic play_game(input game_t g);
    int ans = 0;
    int n   = 0;
    int d;
    if (game_end_o) begin
      pulse_start();
      repeat (2) @(negedge clk);
      chk("done_exit", int'(game_end_o), 0);
      chk("count_kept", int'(round_count_o), 10);
    end
    level_i       = g.level;
    level_valid_i = 1'b1;
    pulse_start();
    chk("lat_gen_a", int'(gen_en_o), 0);
    @(negedge clk);
    chk("rrst_sub_rst", int'(sub_rst_o), 0);
    level_i = 3'b111;  // must not disturb the latched mask
    @(negedge clk);
    chk("lat_gen_c", int'(gen_en_o), 0);
    chk("mask_latch", int'(lv_mask_o), int'(g.mask));
    chk("count_clear", int'(round_count_o), 0);
    @(negedge clk);
    chk("lat_gen_d", int'(gen_en_o), 1);
    chk("gen_sub_rst", int'(sub_rst_o), 1);
    for (int r = 0; r < 10; r++) begin
      d = (g.special && r == 0) ? -1 : (g.special && r == 1) ? 49 : 3;
      if (g.wins[r] && d >= 0) ans++;
      play_round(r, g.wins[r], d, ans);
    end
    while (!game_end_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("game_end", int'(game_end_o), 1);
    chk("final_mask", int'(lv_mask_o), int'(g.mask));
    chk("final_rounds", int'(round_count_o), 10);
    chk("final_answers", int'(answer_count_o), g.ans);
    chk("final_score", int'(score_o), g.score);
    chk("done_sub_rst", int'(sub_rst_o), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    games[0] = '{3'b001, 10'h3FF, 1'b0, 16'h00FF, 10, 100};
    games[1] = '{3'b100, 10'h015, 1'b0, 16'hFFFF, 3, 30};
    games[2] = '{3'b010, 10'h000, 1'b0, 16'h0FFF, 0, 0};
    games[3] = '{3'b010, 10'h2AA, 1'b0, 16'h0FFF, 5, 50};
    games[4] = '{3'b001, 10'h3FF, 1'b1, 16'h00FF, 9, 90};

    rst_ni = 1'b0;
    level_valid_i = 1'b0; level_i = 3'b000; start_i = 1'b0;
    gen_done_i = 1'b0; show_done_i = 1'b0; input_done_i = 1'b0; round_win_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sub_rst", int'(sub_rst_o), 0);
    chk("rst_gen_en", int'(gen_en_o), 0);
    chk("rst_mask", int'(lv_mask_o), 0);
    chk("rst_rounds", int'(round_count_o), 0);
    chk("rst_answers", int'(answer_count_o), 0);
    chk("rst_score", int'(score_o), 0);
    chk("rst_game_end", int'(game_end_o), 0);
    chk("rst_timeout", int'(timeout_o), 0);
    rst_ni = 1'b1;
    @(negedge clk);

    // Illegal or unqualified starts and stray done pulses must leave the FSM idle.
    level_valid_i = 1'b1; level_i = 3'b011;
    pulse_start();
    repeat (6) @(negedge clk);
    chk("multi_hot_gen", int'(gen_en_o), 0);
    chk("multi_hot_mask", int'(lv_mask_o), 0);
    level_i = 3'b000;
    pulse_start();
    repeat (6) @(negedge clk);
    chk("zero_lvl_gen", int'(gen_en_o), 0);
    level_valid_i = 1'b0; level_i = 3'b001;
    pulse_start();
    repeat (6) @(negedge clk);
    chk("novalid_gen", int'(gen_en_o), 0);
    gen_done_i = 1'b1; show_done_i = 1'b1; input_done_i = 1'b1;
    @(negedge clk);
    gen_done_i = 1'b0; show_done_i = 1'b0; input_done_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("spurious_gen", int'(gen_en_o), 0);
    chk("spurious_sub_rst", int'(sub_rst_o), 0);
    chk("spurious_rounds", int'(round_count_o), 0);
    chk("spurious_end", int'(game_end_o), 0);

    for (int i = 0; i < 5; i++) play_game(games[i]);

    // Reset in SHOW of round 4, then a fresh game starts from round 0.
    pulse_start();
    repeat (2) @(negedge clk);
    level_i = 3'b010; level_valid_i = 1'b1;
    pulse_start();
    for (int r = 0; r < 3; r++) play_round(r, 1'b1, 3, r + 1);
    wait_gen();
    gen_done_i = 1'b1;
    @(negedge clk);
    gen_done_i = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk);
    chk("mid_rst_sub_rst", int'(sub_rst_o), 0);
    chk("mid_rst_mask", int'(lv_mask_o), 0);
    chk("mid_rst_rounds", int'(round_count_o), 0);
    chk("mid_rst_answers", int'(answer_count_o), 0);
    chk("mid_rst_score", int'(score_o), 0);
    rst_ni = 1'b1;
    @(negedge clk);
    play_game(games[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
